bit_scan_encoder: RTL and testbench

//   Parametrised sequential successor to the 8-to-3 encoder.
//   - Accepts a WIDTH-bit multi-hot vector over a valid/ready handshake.
//   - Emits the index of every set bit, one beat per handshake, in a selectable priority order.
//   - Unlike the combinational encoder, multiple set bits are fully drained, not collapsed.
//   - Sits between request/flag sources and serial consumers such as interrupt servicing or

---
 rtl/bit_scan_encoder.sv | 101 ++++++++++
 tb/tb_bit_scan_encoder.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/bit_scan_encoder.sv
// Sequential multi-hot encoder: captures a WIDTH-bit vector and drains the index of
// every set bit, one beat per valid/ready handshake, lowest- or highest-first.
module bit_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_none,
    output logic [IDX_W:0]   out_count
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pend, pend_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] pick_idx;
    logic [WIDTH-1:0] pick_mask;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c += CNT_W'(v[i]);
        return c;
    endfunction

    // Last match in loop order wins, so the scan direction sets the priority.
    always_comb begin
        pick_idx  = '0;
        pick_mask = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++)
                if (pend[i]) begin
                    pick_idx     = IDX_W'(i);
                    pick_mask    = '0;
                    pick_mask[i] = 1'b1;
                end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (pend[i]) begin
                    pick_idx     = IDX_W'(i);
                    pick_mask    = '0;
                    pick_mask[i] = 1'b1;
                end
        end
    end

    // Outputs decode only registered state, so nothing from in_* reaches out_*.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign out_idx   = out_valid ? pick_idx : '0;
    assign out_last  = out_valid && ((pend & (pend - WIDTH'(1))) == '0);
    assign out_none  = out_valid && (pend == '0);
    assign out_count = out_valid ? cnt : '0;

    always_comb begin
        state_n = state;
        pend_n  = pend;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    pend_n  = in_vec;
                    cnt_n   = popcount(in_vec);
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_n = pend & ~pick_mask;
                    if (out_last) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            pend  <= pend_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed bench for bit_scan_encoder: LSB-first instance plus an MSB-first twin
// sharing the same stimulus.
module tb_bit_scan_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_last0, out_none0;
    logic [2:0] out_idx0;
    logic [3:0] out_count0;
    logic       in_ready1, out_valid1, out_last1, out_none1;
    logic [2:0] out_idx1;
    logic [3:0] out_count1;

    int n_cmp = 0;
    int n_bad = 0;

    bit_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_vec(in_vec), .out_valid(out_valid0), .out_ready(out_ready),
        .out_idx(out_idx0), .out_last(out_last0), .out_none(out_none0),
        .out_count(out_count0)
    );

    bit_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_vec(in_vec), .out_valid(out_valid1), .out_ready(out_ready),
        .out_idx(out_idx1), .out_last(out_last1), .out_none(out_none1),
        .out_count(out_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the beat presented now, then lets one clock edge go by.
    task automatic expect_beat(input string tag, input int idx, input int last,
                               input int none, input int count);
        chk({tag, " valid"}, 32'(out_valid0), 1);
        chk({tag, " idx"},   32'(out_idx0),   32'(idx));
        chk({tag, " last"},  32'(out_last0),  32'(last));
        chk({tag, " none"},  32'(out_none0),  32'(none));
        chk({tag, " count"}, 32'(out_count0), 32'(count));
        chk({tag, " busy"},  32'(in_ready0),  0);
        @(negedge clk);
    endtask

    task automatic expect_idle(input string tag);
        chk({tag, " idle rdy"}, 32'(in_ready0),  1);
        chk({tag, " idle vld"}, 32'(out_valid0), 0);
    endtask

    task automatic send_vec(input logic [7:0] v);
        in_valid = 1'b1;
        in_vec   = v;
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 8'h00;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        chk("rst in_ready",  32'(in_ready0),  1);
        chk("rst out_valid", 32'(out_valid0), 0);
        chk("rst out_idx",   32'(out_idx0),   0);
        chk("rst out_last",  32'(out_last0),  0);
        chk("rst out_none",  32'(out_none0),  0);
        chk("rst out_count", 32'(out_count0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // zero vector: a single "none" beat, ready again two cycles after acceptance
        send_vec(8'h00);
        expect_beat("zero", 0, 1, 1, 0);
        expect_idle("zero");

        for (int i = 0; i < 8; i++) begin
            send_vec(8'(1 << i));
            expect_beat($sformatf("onehot%0d", i), i, 1, 0, 1);
            expect_idle($sformatf("onehot%0d", i));
        end

        // 0x07: LSB-first gives 0,1,2; MSB-first twin gives 2,1,0
        send_vec(8'h07);
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("msb07 b%0d idx", b),  32'(out_idx1),  32'(2 - b));
            chk($sformatf("msb07 b%0d last", b), 32'(out_last1), 32'(b == 2));
            chk($sformatf("msb07 b%0d cnt", b),  32'(out_count1), 3);
            expect_beat($sformatf("lsb07 b%0d", b), b, (b == 2) ? 1 : 0, 0, 3);
        end
        expect_idle("x07");

        // 0xFF with a 3-cycle stall on beat index 3
        send_vec(8'hFF);
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    chk($sformatf("stall%0d idx", s),  32'(out_idx0),   3);
                    chk($sformatf("stall%0d last", s), 32'(out_last0),  0);
                    chk($sformatf("stall%0d cnt", s),  32'(out_count0), 8);
                    chk($sformatf("stall%0d rdy", s),  32'(in_ready0),  0);
                end
                out_ready = 1'b1;
            end
            expect_beat($sformatf("ff b%0d", b), b, (b == 7) ? 1 : 0, 0, 8);
        end
        expect_idle("xff");

        // 0xA5 (bits 0,2,5,7) cut short by reset after two beats
        send_vec(8'hA5);
        expect_beat("a5 b0", 0, 0, 0, 4);
        expect_beat("a5 b1", 2, 0, 0, 4);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 32'(out_valid0), 0);
        chk("midrst in_ready",  32'(in_ready0),  1);
        chk("midrst out_count", 32'(out_count0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_idle("postrst");
        send_vec(8'h80);
        expect_beat("x80", 7, 1, 0, 1);
        expect_idle("x80");

        // in_valid held high: 0x03 then 0x10, the second vector waits for IDLE
        in_valid = 1'b1;
        in_vec   = 8'h03;
        @(negedge clk);
        in_vec = 8'h10;
        expect_beat("b2b b0", 0, 0, 0, 2);
        expect_beat("b2b b1", 1, 1, 0, 2);
        expect_idle("b2b gap");
        @(negedge clk);
        in_valid = 1'b0;
        in_vec   = 8'h00;
        expect_beat("b2b b2", 4, 1, 0, 1);
        expect_idle("b2b end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
